// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and instruction RAM write port for imem_loader.
// master: loader side; slave: the RX front-end / RAM side.
interface imem_loader_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 7
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output we,
    output waddr,
    output wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  we,
    input  waddr,
    input  wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Assembles a framed byte stream into N-bit words, writes them to instruction RAM and holds
// the CPU in reset while loading. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_loader #(
  parameter int unsigned N          = 32,
  parameter int unsigned AW         = 7,
  parameter logic [7:0]  START_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  localparam int unsigned Bpw      = N / 8;
  localparam int unsigned BiW      = (Bpw > 1) ? $clog2(Bpw) : 1;
  localparam int unsigned MaxWords = 1 << AW;

  typedef enum logic [2:0] {StIdle, StCount, StData, StCheck, StDone, StErr} state_e;

  state_e        state_q, state_d;
  logic          rx_ready_q, rx_ready_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [AW:0]   words_loaded_q, words_loaded_d;
  logic [AW:0]   target_q, target_d;
  logic [BiW-1:0] byte_idx_q, byte_idx_d;
  logic [N-1:0]  asm_q, asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif
  logic          accept;

  always_comb begin
    state_d        = state_q;
    rx_ready_d     = 1'b1;
    we_d           = 1'b0;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    cpu_reset_d    = cpu_reset_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    error_d        = error_q;
    words_loaded_d = words_loaded_q;
    target_d       = target_q;
    byte_idx_d     = byte_idx_q;
    asm_d          = asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d          = chk_q;
`endif
    accept         = bus.rx_valid && rx_ready_q;

    unique case (state_q)
      StIdle: begin
        if (accept && (bus.rx_data == START_BYTE)) begin
          state_d        = StCount;
          busy_d         = 1'b1;
          cpu_reset_d    = 1'b1;
          error_d        = 1'b0;
          words_loaded_d = '0;
          byte_idx_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d          = '0;
`endif
        end
      end
      StCount: begin
        if (accept) begin
          if ((bus.rx_data != 8'd0) && (32'(bus.rx_data) <= MaxWords)) begin
            target_d = (AW+1)'(bus.rx_data);
            state_d  = StData;
          end else begin
            state_d    = StErr;
            rx_ready_d = 1'b0;
            busy_d     = 1'b0;
            error_d    = 1'b1;
          end
        end
      end
      StData: begin
        if (accept) begin
          asm_d[8*byte_idx_q +: 8] = bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ bus.rx_data;
`endif
          if (byte_idx_q == BiW'(Bpw - 1)) begin
            // Word complete: registered write lands the cycle after the last byte.
            byte_idx_d     = '0;
            we_d           = 1'b1;
            waddr_d        = words_loaded_q[AW-1:0];
            wdata_d        = asm_d;
            words_loaded_d = words_loaded_q + (AW+1)'(1);
            if (words_loaded_d == target_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d     = StDone;
              rx_ready_d  = 1'b0;
              busy_d      = 1'b0;
              cpu_reset_d = 1'b0;
              done_d      = 1'b1;
`endif
            end
          end else begin
            byte_idx_d = byte_idx_q + BiW'(1);
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          rx_ready_d = 1'b0;
          busy_d     = 1'b0;
          if (bus.rx_data == chk_q) begin
            state_d     = StDone;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = StErr;
            error_d = 1'b1;
          end
        end
      end
`endif
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      rx_ready_q     <= 1'b1;
      we_q           <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      cpu_reset_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
      target_q       <= '0;
      byte_idx_q     <= '0;
      asm_q          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rx_ready_q     <= rx_ready_d;
      we_q           <= we_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      cpu_reset_q    <= cpu_reset_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
      target_q       <= target_d;
      byte_idx_q     <= byte_idx_d;
      asm_q          <= asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q          <= chk_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_loaded  = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level model driven by observed byte acceptance, checked every cycle.
module tb_imem_loader;
  localparam int unsigned N     = 32;
  localparam int unsigned AW    = 7;
  localparam int unsigned Bpw   = N / 8;
  localparam logic [7:0]  START = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_reset, busy, done, error;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.N(N), .AW(AW)) bus ();

  imem_loader #(.N(N), .AW(AW), .START_BYTE(START)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int we_seen  = 0;
  logic b2b    = 1'b1;
  logic [AW-1:0] last_waddr;
  logic [N-1:0]  dut_mem [128];
  logic [N-1:0]  mdl_mem [128];

  // Model: bytes of the frame after START, interpreted by position.
  logic       in_frame;
  logic [7:0] fr [$];
  int         cnt;
  logic          exp_rx_ready, exp_we, exp_cpu_reset, exp_busy, exp_done, exp_error;
  logic [AW-1:0] exp_waddr;
  logic [N-1:0]  exp_wdata;
  logic [AW:0]   exp_words;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    in_frame = 1'b0; fr.delete(); cnt = 0;
    exp_rx_ready = 1'b1; exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    exp_cpu_reset = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_error = 1'b0; exp_words = '0;
  endtask

  task automatic end_frame(input logic ok);
    in_frame = 1'b0; exp_busy = 1'b0; exp_rx_ready = 1'b0;
    if (ok) begin exp_done = 1'b1; exp_cpu_reset = 1'b0; end
    else exp_error = 1'b1;
  endtask

  task automatic model_step(input logic [7:0] b);
    int n, k;
    logic [N-1:0] w;
    logic [7:0] x;
    if (!in_frame) begin
      if (b == START) begin
        in_frame = 1'b1; fr.delete();
        exp_busy = 1'b1; exp_cpu_reset = 1'b1; exp_error = 1'b0; exp_words = '0;
      end
    end else begin
      fr.push_back(b);
      n = fr.size();
      if (n == 1) begin
        cnt = int'(b);
        if (cnt == 0 || cnt > (1 << AW)) end_frame(1'b0);
      end else if (n <= 1 + cnt * Bpw) begin
        if ((n - 1) % Bpw == 0) begin
          k = (n - 1) / Bpw - 1;
          w = '0;
          for (int i = 0; i < Bpw; i++) w[8*i +: 8] = fr[1 + k*Bpw + i];
          exp_we = 1'b1; exp_waddr = AW'(k); exp_wdata = w; exp_words = (AW+1)'(k + 1);
          mdl_mem[k] = w;
`ifndef IMEM_LOADER_CHECKSUM_EN
          if (n == 1 + cnt * Bpw) end_frame(1'b1);
`endif
        end
      end else begin
        x = '0;
        for (int i = 1; i < n - 1; i++) x ^= fr[i];
        end_frame(x == b);
      end
    end
  endtask

  task automatic compare();
    chk("rx_ready", 64'(bus.rx_ready), 64'(exp_rx_ready));
    chk("we", 64'(bus.we), 64'(exp_we));
    chk("cpu_reset", 64'(cpu_reset), 64'(exp_cpu_reset));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("done", 64'(done), 64'(exp_done));
    chk("error", 64'(error), 64'(exp_error));
    chk("words_loaded", 64'(words_loaded), 64'(exp_words));
    if (exp_we || reset) begin
      chk("waddr", 64'(bus.waddr), 64'(exp_waddr));
      chk("wdata", 64'(bus.wdata), 64'(exp_wdata));
    end
    if (bus.we === 1'b1) begin
      dut_mem[bus.waddr] = bus.wdata;
      we_seen++;
      last_waddr = bus.waddr;
    end
  endtask

  // One clock: check settled outputs, drive inputs, advance model on the upcoming edge.
  task automatic cycle(input logic v, input logic [7:0] d, output logic acc);
    @(negedge clk);
    cyc++;
    compare();
    bus.rx_valid = v;
    bus.rx_data  = d;
    acc = v && (bus.rx_ready === 1'b1) && !reset;
    exp_we = 1'b0; exp_done = 1'b0; exp_rx_ready = 1'b1;
    if (reset) model_reset();
    else if (acc) model_step(d);
  endtask

  task automatic set_reset(input logic val);
    @(negedge clk);
    cyc++;
    compare();
    reset = val;
    bus.rx_valid = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cycle(1'b0, 8'($urandom), acc);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int tries = 0;
    do begin
      cycle(1'b1, b, acc);
      tries++;
    end while (!acc && tries < 6);
    if (!acc) begin
      n_checks++; n_errs++;
      $display("FAIL stall cycle %0d: byte %0h not accepted within 6 cycles", cyc, b);
    end
    if (!b2b && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  task automatic send_frame(input int n_words, input logic bad_chk);
    logic [7:0] x = '0;
    logic [7:0] b;
    send_byte(START);
    send_byte(8'(n_words));
    for (int i = 0; i < n_words * Bpw; i++) begin
      b = ($urandom_range(0, 7) == 0) ? START : 8'($urandom);
      x ^= b;
      send_byte(b);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? ~x : x);
`else
    if (bad_chk) send_byte(8'h5A);
`endif
  endtask

  logic [7:0] tp [9] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'hF8, 8'h02, 8'h80, 8'h00, 8'hF8};

  initial begin
    logic acc;
    logic [7:0] x;
    int r;
    model_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    idle(3);
    set_reset(1'b0);
    idle(2);

    // Directed frame with leading noise.
    b2b = 1'b1;
    we_seen = 0;
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(START);
    cycle(1'b0, 8'h00, acc);
    chk("pin_busy_after_start", 64'(busy), 64'd1);
    chk("pin_noise_no_write", 64'(we_seen), 64'd0);
    x = '0;
    foreach (tp[i]) begin
      send_byte(tp[i]);
      if (i > 0) x ^= tp[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x);
`endif
    idle(3);
    chk("pin_mem0", 64'(dut_mem[0]), 64'hF8000001);
    chk("pin_mem1", 64'(dut_mem[1]), 64'hF8008002);
    chk("pin_model_mem1", 64'(mdl_mem[1]), 64'hF8008002);
    chk("pin_words", 64'(words_loaded), 64'd2);
    chk("pin_cpu_reset_low", 64'(cpu_reset), 64'd0);

    // Illegal counts.
    we_seen = 0;
    send_byte(START); send_byte(8'h00); idle(3);
    chk("pin_cnt0_error", 64'(error), 64'd1);
    chk("pin_cnt0_cpu_reset", 64'(cpu_reset), 64'd1);
    send_byte(START); send_byte(8'h81); idle(3);
    chk("pin_cnt81_error", 64'(error), 64'd1);
    chk("pin_bad_cnt_no_write", 64'(we_seen), 64'd0);

    // Wrong checksum (trailing noise when checksum is disabled), then a good frame.
    send_frame(1, 1'b1); idle(3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("pin_badchk_error", 64'(error), 64'd1);
    chk("pin_badchk_cpu_reset", 64'(cpu_reset), 64'd1);
`else
    chk("pin_noise_tail_error", 64'(error), 64'd0);
    chk("pin_noise_tail_cpu_reset", 64'(cpu_reset), 64'd0);
`endif
    send_frame(2, 1'b0); idle(3);
    chk("pin_good_clears_error", 64'(error), 64'd0);

    // Full 128-word frame, rx_valid held high.
    we_seen = 0;
    send_frame(128, 1'b0); idle(3);
    chk("pin_full_we_count", 64'(we_seen), 64'd128);
    chk("pin_full_last_waddr", 64'(last_waddr), 64'h7F);
    chk("pin_full_words", 64'(words_loaded), 64'h80);

    // Reset mid-DATA after 5 bytes, then a fresh frame.
    send_byte(START); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    set_reset(1'b1); idle(2); set_reset(1'b0);
    we_seen = 0;
    send_frame(2, 1'b0); idle(3);
    chk("pin_after_reset_writes", 64'(we_seen), 64'd2);
    chk("pin_after_reset_words", 64'(words_loaded), 64'd2);

    // Randomized traffic with gaps.
    b2b = 1'b0;
    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_byte(START);
        send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(129, 255)));
      end else if (r == 1) begin
        send_byte(8'($urandom_range(0, 255)));
      end else if (r == 2) begin
        send_byte(START); send_byte(8'h03);
        repeat ($urandom_range(0, 6)) send_byte(8'($urandom));
        set_reset(1'b1); idle(1); set_reset(1'b0);
      end else begin
        send_frame($urandom_range(1, 6), $urandom_range(0, 3) == 0);
      end
      idle($urandom_range(0, 2));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
